// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// It takes a byte stream in this order: a word count, the instruction words
// MSB first, then an XOR checksum. It writes each word to consecutive ROM
// word addresses. The core is held in reset until the checksum matches.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // N = 2^ADDR_W is a legal image size, so the comparison limit is one past the last address
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  state_t            state;
  logic [15:0]       n;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_addr;   // one extra bit so a full-depth image never wraps
  logic [7:0]        chk;
  logic [23:0]       word;        // first three bytes of the word being assembled

  logic              accept;
  logic [31:0]       n_hdr;
  logic [31:0]       next_addr;

  // ready depends only on state; qualifying it with rst keeps it low during the reset cycle
  always_comb begin
    in_ready = rst && ((state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_DATA)   || (state == S_CHK));
  end

  assign accept    = in_valid && in_ready;
  assign n_hdr     = {16'd0, n[15:8], in_data};
  assign next_addr = 32'(word_addr) + 32'd1;

  // loader FSM: header capture, word assembly, write strobe and checksum verdict
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HDR_HI;
      n         <= '0;
      byte_idx  <= '0;
      word_addr <= '0;
      chk       <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          S_HDR_HI: begin
            n[15:8] <= in_data;
            state   <= S_HDR_LO;
          end
          S_HDR_LO: begin
            n[7:0] <= in_data;
            if (n_hdr > DEPTH) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (n_hdr == 32'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            word     <= {word[15:0], in_data};
            chk      <= chk ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_addr[ADDR_W-1:0];
              mem_wdata <= {word, in_data};
              word_addr <= word_addr + {{ADDR_W{1'b0}}, 1'b1};
              if (next_addr == {16'd0, n}) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (in_data == chk) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// dut uses the full 16-bit address width. dut2 uses ADDR_W=2 to exercise the size limits.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2;
  logic [7:0]  in_data, in_data2;
  logic        in_ready, in_ready2;
  logic        mem_we, mem_we2;
  logic [15:0] mem_addr;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2;
  logic        cpu_rst_n, cpu_rst_n2;
  logic        done, done2;
  logic        err, err2;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_rst_n(cpu_rst_n2), .done(done2), .err(err2)
  );

  // one clock; sample 1 time unit after the edge and retire any write against the scoreboard
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%h data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        e = q1.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL wr got addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (mem_we2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL wr2_unexpected got addr=%h data=%h required=no write", mem_addr2, mem_wdata2);
      end else begin
        e = q2.pop_front();
        if ({14'd0, mem_addr2} !== e.addr || mem_wdata2 !== e.data) begin
          errors++;
          $display("FAIL wr2 got addr=%h data=%h required addr=%h data=%h",
                   mem_addr2, mem_wdata2, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic send(input bit which, input logic [7:0] b);
    checks++;
    if ((which ? in_ready2 : in_ready) !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_send got=%b required=1", which ? in_ready2 : in_ready);
    end
    if (which) begin in_valid2 = 1'b1; in_data2 = b; end
    else       begin in_valid  = 1'b1; in_data  = b; end
    step();
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic send_word(input bit which, input logic [15:0] addr, input logic [31:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    if (which) q2.push_back(e); else q1.push_back(e);
    for (int i = 3; i >= 0; i--) send(which, w[i*8 +: 8]);
  endtask

  task automatic test_reset();
    q1.delete();
    q2.delete();
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_data = 8'h00; in_data2 = 8'h00;
    step();
    step();
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, err} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h crn=%b done=%b err=%b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, err);
    end
    checks++;
    if ({in_ready2, mem_we2, mem_addr2, mem_wdata2, cpu_rst_n2, done2, err2} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs2 got rdy=%b we=%b a=%h d=%h crn=%b done=%b err=%b required all 0",
               in_ready2, mem_we2, mem_addr2, mem_wdata2, cpu_rst_n2, done2, err2);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b%b required=11", in_ready, in_ready2);
    end
  endtask

  task automatic load_two_words(input logic [7:0] ck);
    send(0, 8'h00);
    send(0, 8'h02);
    send_word(0, 16'd0, 32'h20080005);
    send(0, 8'h00);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 16'd0 || mem_wdata !== 32'h20080005) begin
      errors++;
      $display("FAIL write_hold got we=%b a=%h d=%h required we=0 a=0000 d=20080005",
               mem_we, mem_addr, mem_wdata);
    end
    send(0, 8'h00); send(0, 8'h00);
    wr_t_push(16'd1, 32'h00000008);
    send(0, 8'h08);
    checks++;
    if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL pre_chk got crn=%b done=%b required 0 0", cpu_rst_n, done);
    end
    send(0, ck);
  endtask

  task automatic wr_t_push(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q1.push_back(e);
  endtask

  task automatic test_basic();
    test_reset();
    load_two_words(8'h25);
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b crn=%b err=%b rdy=%b required 1 1 0 0",
               done, cpu_rst_n, err, in_ready);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL basic_writes got pending=%0d required=0", q1.size());
    end
  endtask

  task automatic test_bad_chk();
    test_reset();
    load_two_words(8'h24);
    step();
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk got err=%b done=%b crn=%b rdy=%b required 1 0 0 0",
               err, done, cpu_rst_n, in_ready);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL bad_chk_writes got pending=%0d required=0", q1.size());
    end
  endtask

  task automatic test_empty();
    test_reset();
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL empty_ok got done=%b crn=%b err=%b required 1 1 0", done, cpu_rst_n, err);
    end
    test_reset();
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h01);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL empty_badchk got err=%b done=%b crn=%b required 1 0 0", err, done, cpu_rst_n);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] bytes [7];
    bytes = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    test_reset();
    wr_t_push(16'd0, 32'h12345678);
    for (int i = 0; i < 7; i++) begin
      send(0, bytes[i]);
      for (int k = 0; k < 2 && i < 6; k++) begin
        in_data = 8'($urandom);
        step();
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || q1.size() != 0) begin
      errors++;
      $display("FAIL bubbles got done=%b err=%b pending=%0d required 1 0 0", done, err, q1.size());
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    send(0, 8'h00); send(0, 8'h01); send(0, 8'hDE); send(0, 8'hAD);
    test_reset();
    send(0, 8'h00); send(0, 8'h01);
    send_word(0, 16'd0, 32'hDEADBEEF);
    send(0, 8'h22);
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0 || q1.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_reload got done=%b crn=%b err=%b pending=%0d required 1 1 0 0",
               done, cpu_rst_n, err, q1.size());
    end
  endtask

  task automatic test_oversize();
    logic [7:0]  ck;
    logic [31:0] w;
    test_reset();
    send(1, 8'h00); send(1, 8'h05);
    step();
    checks++;
    if (err2 !== 1'b1 || done2 !== 1'b0 || in_ready2 !== 1'b0) begin
      errors++;
      $display("FAIL oversize got err=%b done=%b rdy=%b required 1 0 0", err2, done2, in_ready2);
    end
    test_reset();
    send(1, 8'h00); send(1, 8'h04);
    ck = 8'h00;
    for (int i = 0; i < 4; i++) begin
      w = 32'h01020304 + 32'(i) * 32'h04040404;
      ck = ck ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(1, 16'(i), w);
    end
    send(1, ck);
    checks++;
    if (done2 !== 1'b1 || cpu_rst_n2 !== 1'b1 || err2 !== 1'b0 || q2.size() != 0) begin
      errors++;
      $display("FAIL full_depth got done=%b crn=%b err=%b pending=%0d required 1 1 0 0",
               done2, cpu_rst_n2, err2, q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_empty();
    test_bubbles();
    test_reset_mid();
    test_oversize();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle processor. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction ROM. The word address uses the same indexing the fetch unit reads with (byte PC bits [17:2]). The loader holds the processor core in reset until the image is fully loaded and its checksum verified, then releases it so fetch starts at PC 0.

## Interface
- ADDR_W, 16, word-address width; memory depth is 2^ADDR_W words.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  instruction word.
- cpu_rst_n  out  1  active-low reset to the core; high only after a successful load.
- done  out  1  load completed with good checksum (sticky until rst).
- err  out  1  load failed (sticky until rst).

## Operation
- Stream format:
  - N_HI, N_LO: 16-bit word count N, big-endian.
  - 4·N data bytes; each word is sent MSB first, so the first byte lands in bits [31:24].
  - CHK: XOR of all 4·N data bytes. Header bytes are not included.
- A byte is accepted on any rising edge where in_valid && in_ready. No other edge changes the counters.
- States and transitions:
  - HDR_HI: capture N[15:8], go to HDR_LO.
  - HDR_LO: capture N[7:0].
    - If N > 2^ADDR_W, go to ERR.
    - Else if N == 0, go to CHK.
    - Else go to DATA.
  - DATA: shift the byte into the word assembler, XOR it into the running checksum, increment byte_idx (2 bits).
    - When byte_idx wraps 3→0, issue a write at word_addr, then increment word_addr.
    - When word_addr reaches N, go to CHK.
  - CHK:
    - Accepted byte == running checksum: go to DONE.
    - Otherwise: go to ERR.
  - DONE: in_ready=0, done=1, cpu_rst_n=1. Stay until rst.
  - ERR: in_ready=0, err=1, cpu_rst_n=0. Stay until rst.
- in_ready = 1 in HDR_HI, HDR_LO, DATA, CHK. It is decoded from state only and does not depend on in_valid.
- The word address counter is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and the counter does not wrap.
- mem_addr carries the ADDR_W LSBs of the counter.
- The checksum is 8-bit XOR with no carry. For N == 0 it starts at 8'h00.

## Timing
- Reset values (edge with rst=0):
  - State HDR_HI; N, byte_idx, word_addr, checksum all 0.
  - in_ready=0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_n=0, done=0, err=0.
- Reset mid-load: the partial word is discarded, no write is issued, and cpu_rst_n goes low (or stays low). Memory already written is not cleared.
- Write latency: mem_we, mem_addr and mem_wdata are registered. They are valid in the cycle immediately after the edge that accepts the 4th byte of a word. mem_we is high for exactly one cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Throughput: one byte per cycle at most. A word can be written every 4 cycles, and mem_we is never high on two consecutive cycles.
- done and cpu_rst_n both rise on the cycle after the CHK byte is accepted. The last mem_we occurs no later than the CHK acceptance edge, so memory is complete before the core leaves reset.
- err rises on the cycle after the failing byte is accepted.
- Stalls: in_valid may drop at any point. State and partial word are held indefinitely, and there is no timeout.

## Test plan
- Basic load, N=2:
  - Stream 00 02 | 20 08 00 05 | 00 00 00 08 | CHK=0x25.
  - Writes: addr 0 = 32'h20080005, then addr 1 = 32'h00000008, each mem_we one cycle.
  - Then done=1 and cpu_rst_n=1 on the cycle after CHK; err=0.
- Bad checksum:
  - Same stream with CHK=0x24.
  - Both words are written, then err=1, done=0, cpu_rst_n stays 0, and in_ready=0 thereafter.
- Empty image:
  - Stream 00 00 00.
  - No mem_we; done=1 two cycles after the first byte is accepted.
  - Variant with 00 00 01: err=1.
- Backpressure/bubbles:
  - N=1 with in_valid toggled 1,0,0,1,… between bytes.
  - Exactly one write of the correct word. No write and no byte_idx advance on any cycle where in_valid=0.
- Reset mid-word:
  - Apply rst=0 after 2 of 4 data bytes.
  - No mem_we; all outputs return to reset values.
  - A subsequent full stream 00 01 | DE AD BE EF | CHK=0x22 writes addr 0 = 32'hDEADBEEF and sets done.
- Oversize header with ADDR_W=2:
  - Stream 00 05.
  - err=1 after the header, with no writes.
  - Stream 00 04 plus 16 bytes and a correct CHK writes addrs 0..3 and sets done.
